// File: rtl/rtc_read_sequencer_pkg.sv
// Shared definitions for the RTC read sequencer: register address table,
// burst length, state encoding and the null capture address.
package rtc_read_sequencer_pkg;

    localparam int NUM_REGS = 11;
    localparam logic [7:0] NULL_ADDR = 8'h00;

    // Clock/date registers first, then the timer block.
    localparam logic [7:0] REG_TABLE [NUM_REGS] = '{
        8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
        8'h41, 8'h42, 8'h43
    };

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP1,
        READ,
        PUB,
        GAP2
    } state_t;

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        if (int'(idx) < NUM_REGS) begin
            return REG_TABLE[int'(idx)];
        end
        return NULL_ADDR;
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; expired is high on the last
// cycle of the loaded interval (load value N gives N+1 cycles).
module rtc_bus_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expired
);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign expired = (count == 4'd0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Reads the 11 RTC clock/date/timer registers over the multiplexed AD bus
// and publishes each (address, data) pair for one cycle to the capture bank.
module rtc_read_sequencer
    import rtc_read_sequencer_pkg::*;
#(
    parameter int T_PULSE = 4,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] address,
    output logic [7:0] data_vga,
    output logic       busy,
    output logic       done,
    output logic [3:0] index
);

    localparam logic [3:0] PULSE_LOAD = 4'(T_PULSE - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(T_GAP - 1);
    localparam logic [3:0] LAST_INDEX = 4'(NUM_REGS - 1);

    state_t     state;
    state_t     next_state;
    logic       phase_expired;
    logic       timer_load;
    logic [3:0] timer_val;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)         next_state = ADDR;
            ADDR:    if (phase_expired) next_state = GAP1;
            GAP1:    if (phase_expired) next_state = READ;
            READ:    if (phase_expired) next_state = PUB;
            PUB:                        next_state = GAP2;
            GAP2:    if (phase_expired) next_state = (index == LAST_INDEX) ? IDLE : ADDR;
            default:                    next_state = IDLE;
        endcase
    end

    // The timer is reloaded on entry to every timed phase; PUB is fixed at one cycle.
    always_comb begin
        timer_load = (next_state != state) &&
                     (next_state inside {ADDR, GAP1, READ, GAP2});
        timer_val  = (next_state inside {ADDR, READ}) ? PULSE_LOAD : GAP_LOAD;
    end

    rtc_bus_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (phase_expired)
    );

    // Outputs are set on the edge that enters a state and held throughout it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            index    <= 4'd0;
            cs_n     <= 1'b1;
            ad_n     <= 1'b1;
            wr_n     <= 1'b1;
            rd_n     <= 1'b1;
            ad_oe    <= 1'b0;
            ad_out   <= NULL_ADDR;
            address  <= NULL_ADDR;
            data_vga <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            if (next_state != state) begin
                case (next_state)
                    ADDR: begin
                        if (state == IDLE) begin
                            index  <= 4'd0;
                            busy   <= 1'b1;
                            ad_out <= reg_addr(4'd0);
                        end else begin
                            index  <= index + 4'd1;
                            ad_out <= reg_addr(index + 4'd1);
                        end
                        cs_n  <= 1'b0;
                        ad_n  <= 1'b0;
                        wr_n  <= 1'b0;
                        rd_n  <= 1'b1;
                        ad_oe <= 1'b1;
                    end
                    READ: begin
                        cs_n <= 1'b0;
                        ad_n <= 1'b1;
                        wr_n <= 1'b1;
                        rd_n <= 1'b0;
                    end
                    PUB: begin
                        cs_n     <= 1'b1;
                        rd_n     <= 1'b1;
                        address  <= reg_addr(index);
                        data_vga <= ad_in;
                    end
                    IDLE: begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                    default: begin
                        cs_n    <= 1'b1;
                        ad_n    <= 1'b1;
                        wr_n    <= 1'b1;
                        rd_n    <= 1'b1;
                        ad_oe   <= 1'b0;
                        ad_out  <= NULL_ADDR;
                        address <= NULL_ADDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Bench for rtc_read_sequencer: an RTC bus model answers each read with the
// latched address XOR a mask; bursts are compared against a timing/data model.
module tb_rtc_read_sequencer;

    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } pub_t;

    logic [7:0] ref_addr [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                  8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start_f = 1'b0;
    logic [7:0] ad_in, ad_out, address, data_vga;
    logic       ad_oe, cs_n, ad_n, wr_n, rd_n, busy, done;
    logic [3:0] index;
    logic [7:0] ad_in_f, ad_out_f, address_f, data_vga_f;
    logic       ad_oe_f, cs_n_f, ad_n_f, wr_n_f, rd_n_f, busy_f, done_f;
    logic [3:0] index_f;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_read_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
        .address(address), .data_vga(data_vga), .busy(busy), .done(done), .index(index)
    );

    rtc_read_sequencer #(.T_PULSE(1), .T_GAP(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start_f), .ad_in(ad_in_f), .ad_out(ad_out_f),
        .ad_oe(ad_oe_f), .cs_n(cs_n_f), .ad_n(ad_n_f), .wr_n(wr_n_f), .rd_n(rd_n_f),
        .address(address_f), .data_vga(data_vga_f), .busy(busy_f), .done(done_f),
        .index(index_f)
    );

    // RTC models: latch the address phase, return latch ^ mask on reads.
    logic [7:0] rtc_latch = 8'h00, rtc_latch_f = 8'h00;
    logic [7:0] rtc_mask = 8'hFF, rtc_mask_f = 8'hFF;
    always @(posedge clk) begin
        if (!cs_n && !ad_n) rtc_latch <= ad_out;
        if (!cs_n_f && !ad_n_f) rtc_latch_f <= ad_out_f;
    end
    assign ad_in   = rtc_latch ^ rtc_mask;
    assign ad_in_f = rtc_latch_f ^ rtc_mask_f;

    // Bus monitors, sampled mid-cycle.
    pub_t pub_q[$], pub_f_q[$];
    int   done_q[$], done_f_q[$], addr_len_q[$], addr_len_f_q[$], addr_start_q[$];
    int   n_oe_rd = 0, n_wr_rd = 0, n_unstable = 0, addr_len = 0, addr_len_f = 0;
    logic [7:0] addr_val = 8'h00;

    always @(negedge clk) begin
        if (!reset && address !== 8'h00) pub_q.push_back('{cyc, address, data_vga});
        if (done === 1'b1) done_q.push_back(cyc);
        if (ad_oe === 1'b1 && rd_n === 1'b0) n_oe_rd++;
        if (wr_n === 1'b0 && rd_n === 1'b0) n_wr_rd++;
        if (cs_n === 1'b0 && ad_n === 1'b0) begin
            if (addr_len == 0) begin
                addr_start_q.push_back(cyc);
                addr_val = ad_out;
            end else if (ad_out !== addr_val) begin
                n_unstable++;
            end
            addr_len++;
        end else if (addr_len != 0) begin
            addr_len_q.push_back(addr_len);
            addr_len = 0;
        end
        if (!reset && address_f !== 8'h00) pub_f_q.push_back('{cyc, address_f, data_vga_f});
        if (done_f === 1'b1) done_f_q.push_back(cyc);
        if (cs_n_f === 1'b0 && ad_n_f === 1'b0) addr_len_f++;
        else if (addr_len_f != 0) begin
            addr_len_f_q.push_back(addr_len_f);
            addr_len_f = 0;
        end
    end

    task automatic wait_done(input bit fast, input int limit, output bit ok, output logic busy_seen);
        ok = 1'b0;
        busy_seen = 1'bx;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((fast ? done_f : done) === 1'b1) begin
                ok = 1'b1;
                busy_seen = fast ? busy_f : busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        start_f = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cs_n, ad_n, wr_n, rd_n, ad_oe} !== 5'b11110) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 11110", {cs_n, ad_n, wr_n, rd_n, ad_oe});
        end
        n_checks++;
        if ({ad_out, address, data_vga} !== 24'h0) begin
            n_fail++; $display("FAIL reset_buses: got %h expected 000000", {ad_out, address, data_vga});
        end
        n_checks++;
        if ({busy, done, index} !== 6'b0) begin
            n_fail++; $display("FAIL reset_status: got %b expected 000000", {busy, done, index});
        end
        n_checks++;
        if ({cs_n_f, rd_n_f, busy_f, address_f} !== {3'b110, 8'h00}) begin
            n_fail++; $display("FAIL reset_fast: got %h expected %h", {cs_n_f, rd_n_f, busy_f, address_f}, {3'b110, 8'h00});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One full burst at defaults with the given RTC mask.
    task automatic test_burst(input logic [7:0] mask);
        int pb, db, ab, oe0, wr0, un0, k, n;
        bit ok;
        logic busy_at_done;
        rtc_mask = mask;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        pb = pub_q.size(); db = done_q.size(); ab = addr_len_q.size();
        oe0 = n_oe_rd; wr0 = n_wr_rd; un0 = n_unstable;
        k = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 400, ok, busy_at_done);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL burst_done_seen: got none expected done within 400 cycles"); end
        n_checks++;
        if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL burst_busy_at_done: got %b expected 0", busy_at_done); end
        repeat (4) @(negedge clk);
        n = pub_q.size() - pb;
        n_checks++;
        if (n != 11) begin n_fail++; $display("FAIL burst_pub_count: got %0d expected 11", n); end
        for (int i = 0; i < n && i < 11; i++) begin
            n_checks++;
            if (pub_q[pb+i].a !== ref_addr[i] || pub_q[pb+i].d !== (ref_addr[i] ^ mask) ||
                pub_q[pb+i].c != k + 11 + 13 * i) begin
                n_fail++;
                $display("FAIL burst_pub[%0d]: got a=%h d=%h c=%0d expected a=%h d=%h c=%0d", i,
                         pub_q[pb+i].a, pub_q[pb+i].d, pub_q[pb+i].c - k,
                         ref_addr[i], ref_addr[i] ^ mask, 11 + 13 * i);
            end
        end
        n_checks++;
        if (done_q.size() - db != 1 || (done_q.size() > db && done_q[db] != k + 144)) begin
            n_fail++; $display("FAIL burst_done_time: got %0d dones, first at k+%0d expected 1 at k+144",
                               done_q.size() - db, done_q.size() > db ? done_q[db] - k : -1);
        end
        n_checks++;
        if (addr_len_q.size() - ab != 11) begin
            n_fail++; $display("FAIL burst_addr_windows: got %0d expected 11", addr_len_q.size() - ab);
        end
        for (int i = ab; i < addr_len_q.size(); i++) begin
            n_checks++;
            if (addr_len_q[i] != 4) begin
                n_fail++; $display("FAIL burst_addr_len[%0d]: got %0d expected 4", i - ab, addr_len_q[i]);
            end
        end
        n_checks++;
        if (n_unstable - un0 != 0 || n_oe_rd - oe0 != 0 || n_wr_rd - wr0 != 0) begin
            n_fail++; $display("FAIL burst_protocol: got unstable=%0d oe_rd=%0d wr_rd=%0d expected 0 0 0",
                               n_unstable - un0, n_oe_rd - oe0, n_wr_rd - wr0);
        end
    endtask

    task automatic test_reset_mid_read();
        int pb, n;
        bit found;
        rtc_mask = 8'hFF;
        pb = pub_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (index === 4'd5 && rd_n === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rmid_reach_read5: got none expected READ of index 5"); end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cs_n, ad_n, wr_n, rd_n, ad_oe, busy, done} !== 7'b1111000 || index !== 4'd0 ||
            address !== 8'h00) begin
            n_fail++; $display("FAIL rmid_after_reset: got %b idx=%0d addr=%h expected 1111000 idx=0 addr=00",
                               {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, done}, index, address);
        end
        reset = 1'b0;
        repeat (200) @(negedge clk);
        n = pub_q.size() - pb;
        n_checks++;
        if (n != 5) begin n_fail++; $display("FAIL rmid_pub_count: got %0d expected 5", n); end
        for (int i = pb; i < pub_q.size(); i++) begin
            n_checks++;
            if (pub_q[i].a === 8'h26) begin
                n_fail++; $display("FAIL rmid_no_0x26: got address 26 at cycle %0d expected none", pub_q[i].c);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_no_resume: got busy=%b expected 0", busy); end
    endtask

    task automatic test_busy_start();
        int pb, db, k;
        bit found, ok;
        logic busy_at_done;
        rtc_mask = 8'($urandom);
        pb = pub_q.size(); db = done_q.size();
        k = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (index === 4'd3) found = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 400, ok, busy_at_done);
        repeat (20) @(negedge clk);
        n_checks++;
        if (!found || !ok) begin n_fail++; $display("FAIL busy_progress: got idx3=%b done=%b expected 1 1", found, ok); end
        n_checks++;
        if (pub_q.size() - pb != 11) begin
            n_fail++; $display("FAIL busy_pub_count: got %0d expected 11", pub_q.size() - pb);
        end
        n_checks++;
        if (done_q.size() - db != 1 || (done_q.size() > db && done_q[db] != k + 144)) begin
            n_fail++; $display("FAIL busy_single_done: got %0d dones expected 1 at k+144", done_q.size() - db);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int pb, db, asb, k, d1;
        bit ok1, ok2;
        logic b1, b2;
        rtc_mask = 8'hFF;
        pb = pub_q.size(); db = done_q.size(); asb = addr_start_q.size();
        k = cyc;
        start = 1'b1;
        wait_done(1'b0, 400, ok1, b1);
        d1 = cyc;
        repeat ($urandom_range(2, 30)) @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 400, ok2, b2);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok1 || !ok2) begin n_fail++; $display("FAIL b2b_done_seen: got %b%b expected 11", ok1, ok2); end
        n_checks++;
        if (d1 != k + 144) begin n_fail++; $display("FAIL b2b_first_done: got k+%0d expected k+144", d1 - k); end
        n_checks++;
        if (done_q.size() - db != 2 || (done_q.size() > db + 1 && done_q[db+1] != d1 + 144)) begin
            n_fail++; $display("FAIL b2b_second_done: got %0d dones expected 2, second at first+144", done_q.size() - db);
        end
        n_checks++;
        if (addr_start_q.size() < asb + 12 || addr_start_q[asb+11] != d1 + 1) begin
            n_fail++; $display("FAIL b2b_addr_after_done: got %0d expected %0d",
                               addr_start_q.size() >= asb + 12 ? addr_start_q[asb+11] : -1, d1 + 1);
        end
        n_checks++;
        if (pub_q.size() - pb != 22) begin
            n_fail++; $display("FAIL b2b_pub_count: got %0d expected 22", pub_q.size() - pb);
        end
    endtask

    task automatic test_fast_timing();
        int pb, db, ab, k, n;
        bit ok;
        logic busy_at_done;
        logic [7:0] mask;
        mask = 8'($urandom);
        rtc_mask_f = mask;
        pb = pub_f_q.size(); db = done_f_q.size(); ab = addr_len_f_q.size();
        k = cyc;
        start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        wait_done(1'b1, 200, ok, busy_at_done);
        repeat (4) @(negedge clk);
        n_checks++;
        if (!ok || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL fast_done_seen: got ok=%b busy=%b expected 1 0", ok, busy_at_done);
        end
        n = pub_f_q.size() - pb;
        n_checks++;
        if (n != 11) begin n_fail++; $display("FAIL fast_pub_count: got %0d expected 11", n); end
        for (int i = 0; i < n && i < 11; i++) begin
            n_checks++;
            if (pub_f_q[pb+i].a !== ref_addr[i] || pub_f_q[pb+i].d !== (ref_addr[i] ^ mask) ||
                pub_f_q[pb+i].c != k + 4 + 5 * i) begin
                n_fail++;
                $display("FAIL fast_pub[%0d]: got a=%h d=%h c=k+%0d expected a=%h d=%h c=k+%0d", i,
                         pub_f_q[pb+i].a, pub_f_q[pb+i].d, pub_f_q[pb+i].c - k,
                         ref_addr[i], ref_addr[i] ^ mask, 4 + 5 * i);
            end
        end
        n_checks++;
        if (done_f_q.size() - db != 1 || (done_f_q.size() > db && done_f_q[db] != k + 56)) begin
            n_fail++; $display("FAIL fast_done_time: got %0d dones, at k+%0d expected 1 at k+56",
                               done_f_q.size() - db, done_f_q.size() > db ? done_f_q[db] - k : -1);
        end
        n_checks++;
        if (addr_len_f_q.size() - ab != 11) begin
            n_fail++; $display("FAIL fast_addr_windows: got %0d expected 11", addr_len_f_q.size() - ab);
        end
        for (int i = ab; i < addr_len_f_q.size(); i++) begin
            n_checks++;
            if (addr_len_f_q[i] != 1) begin
                n_fail++; $display("FAIL fast_addr_len[%0d]: got %0d expected 1", i - ab, addr_len_f_q[i]);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_burst(8'hFF);
        test_burst(8'($urandom));
        test_reset_mid_read();
        test_busy_start();
        test_back_to_back();
        test_fast_timing();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
